// File: rtl/ps2_cmd_sequencer.sv
// rtl/ps2_cmd_sequencer.sv - acknowledged, retrying PS/2 host command sequencer
//
// Sends a command byte and an optional argument byte through ps2_tx.
// After each byte it waits for the device ACK (0xFA) on ps2_rx.
// A RESEND (0xFE) or a silent window of TIMEOUT_CYC cycles triggers a retransmission.
// Each byte gets its own budget of MAX_RETRY retransmissions.
// Optional feature macro: PS2_CMD_LAST_RESP_EN (adds last_resp output).
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   cmd_req                       start pulse, sampled only when idle
//   cmd_byte, arg_byte, has_arg   transaction request, latched on cmd_req
//   cmd_busy                      high whenever not idle
//   cmd_done_tick, cmd_err_tick   one-cycle completion / failure pulses
//   wr_ps2, din                   write request and byte to ps2_tx
//   tx_done_tick                  ps2_tx frame complete
//   rx_done_tick, rx_data         ps2_rx received byte
//   last_resp                     last byte seen while waiting (PS2_CMD_LAST_RESP_EN only)
module ps2_cmd_sequencer #(
    parameter int TIMEOUT_CYC = 2_500_000,
    parameter int MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_req,
    input  logic [7:0] cmd_byte,
    input  logic [7:0] arg_byte,
    input  logic       has_arg,
    output logic       cmd_busy,
    output logic       cmd_done_tick,
    output logic       cmd_err_tick,
    output logic       wr_ps2,
    output logic [7:0] din,
    input  logic       tx_done_tick,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data
`ifdef PS2_CMD_LAST_RESP_EN
    ,
    output logic [7:0] last_resp
`endif
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRY);
    localparam logic [7:0] RESP_ACK    = 8'hFA;
    localparam logic [7:0] RESP_RESEND = 8'hFE;

    typedef enum logic [2:0] {
        S_IDLE, S_SEND_CMD, S_WAIT_CMD, S_SEND_ARG, S_WAIT_ARG, S_DONE, S_ERR
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [7:0]      arg_q, arg_d;
    logic            has_arg_q, has_arg_d;

    logic is_ack, is_retry, in_wait;

    // An ACK in the same cycle as the timeout wins because it is tested first.
    assign is_ack   = rx_done_tick && (rx_data == RESP_ACK);
    assign is_retry = (rx_done_tick && (rx_data == RESP_RESEND)) || (timer_q == T_LAST);
    assign in_wait  = (state_q == S_WAIT_CMD) || (state_q == S_WAIT_ARG);

    always_comb begin
        state_d   = state_q;
        timer_d   = '0;
        retry_d   = retry_q;
        cmd_d     = cmd_q;
        arg_d     = arg_q;
        has_arg_d = has_arg_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_req) begin
                    cmd_d     = cmd_byte;
                    arg_d     = arg_byte;
                    has_arg_d = has_arg;
                    retry_d   = '0;
                    state_d   = S_SEND_CMD;
                end
            end
            S_SEND_CMD: if (tx_done_tick) state_d = S_WAIT_CMD;
            S_SEND_ARG: if (tx_done_tick) state_d = S_WAIT_ARG;
            S_WAIT_CMD, S_WAIT_ARG: begin
                timer_d = timer_q + 1'b1;
                if (is_ack) begin
                    retry_d = '0;
                    if (state_q == S_WAIT_CMD && has_arg_q) state_d = S_SEND_ARG;
                    else                                    state_d = S_DONE;
                end else if (is_retry) begin
                    if (retry_q < R_MAX) begin
                        retry_d = retry_q + 1'b1;
                        state_d = (state_q == S_WAIT_CMD) ? S_SEND_CMD : S_SEND_ARG;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Timer restarts on every state change so it never wraps.
        if (state_d != state_q) timer_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            retry_q   <= '0;
            cmd_q     <= '0;
            arg_q     <= '0;
            has_arg_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            cmd_q     <= cmd_d;
            arg_q     <= arg_d;
            has_arg_q <= has_arg_d;
        end
    end

`ifdef PS2_CMD_LAST_RESP_EN
    logic [7:0] last_resp_q;
    // Every byte seen while waiting is kept, including stray scan codes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      last_resp_q <= 8'h00;
        else if (rx_done_tick && in_wait) last_resp_q <= rx_data;
    end
    assign last_resp = last_resp_q;
`else
    logic unused_in_wait;
    assign unused_in_wait = in_wait;
`endif

    // Outputs decode the state register directly, so reset clears them asynchronously.
    assign cmd_busy      = (state_q != S_IDLE);
    assign cmd_done_tick = (state_q == S_DONE);
    assign cmd_err_tick  = (state_q == S_ERR);
    assign wr_ps2        = (state_q == S_SEND_CMD) || (state_q == S_SEND_ARG);
    assign din           = (state_q == S_SEND_CMD) ? cmd_q :
                           (state_q == S_SEND_ARG) ? arg_q : 8'h00;

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// tb/tb_ps2_cmd_sequencer.sv - scoreboard testbench for ps2_cmd_sequencer
module tb_ps2_cmd_sequencer;

    localparam int TO = 100;
    localparam int MR = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_req = 1'b0;
    logic [7:0] cmd_byte = 8'h00;
    logic [7:0] arg_byte = 8'h00;
    logic       has_arg = 1'b0;
    logic       cmd_busy, cmd_done_tick, cmd_err_tick, wr_ps2;
    logic [7:0] din;
    logic       tx_done_tick = 1'b0;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_data = 8'h00;
`ifdef PS2_CMD_LAST_RESP_EN
    logic [7:0] last_resp;
`endif

    ps2_cmd_sequencer #(.TIMEOUT_CYC(TO), .MAX_RETRY(MR)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_req(cmd_req), .cmd_byte(cmd_byte),
        .arg_byte(arg_byte), .has_arg(has_arg), .cmd_busy(cmd_busy),
        .cmd_done_tick(cmd_done_tick), .cmd_err_tick(cmd_err_tick),
        .wr_ps2(wr_ps2), .din(din), .tx_done_tick(tx_done_tick),
        .rx_done_tick(rx_done_tick), .rx_data(rx_data)
`ifdef PS2_CMD_LAST_RESP_EN
        , .last_resp(last_resp)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         dly;
        bit         silent;
        bit         pre;
        logic [7:0] b;
    } resp_t;

    int tests = 0, fails = 0;
    int cyc = 0, done_cnt = 0, err_cnt = 0, frames = 0;
    int last_txd = -1, last_rx = -1000, err_gap = 0;
    int gaps[$];
    logic [7:0] exp_q[$];
    resp_t resp_q[$];

    bit    tx_busy = 0, rsp_pend = 0, chk_busy = 0;
    int    tx_cnt = 0, rsp_cnt = 0;
    resp_t rsp_cur;

    task automatic push_resp(input int dly, input bit silent, input bit pre, input logic [7:0] b);
        resp_t r;
        r.dly = dly; r.silent = silent; r.pre = pre; r.b = b;
        resp_q.push_back(r);
    endtask

    // ps2_tx / device model plus output monitor, all on the falling edge.
    always @(negedge clk) begin
        cyc++;
        tx_done_tick = 1'b0;
        rx_done_tick = 1'b0;
        if (!rst_n) begin
            tx_busy = 0; rsp_pend = 0; chk_busy = 0;
        end else begin
            if (chk_busy) begin
                chk_busy = 0;
                tests++;
                if (cmd_busy !== 1'b0) begin
                    fails++; $display("FAIL busy_after_done: got %b want 0", cmd_busy);
                end
            end
            if (cmd_done_tick) begin
                done_cnt++;
                chk_busy = 1;
                tests++;
                if (cyc - last_rx != 1) begin
                    fails++; $display("FAIL done_latency: got %0d want 1", cyc - last_rx);
                end
            end
            if (cmd_err_tick) begin
                err_cnt++;
                err_gap = cyc - last_txd;
            end
            if (rsp_pend) begin
                rsp_cnt--;
                if (rsp_cnt <= 0) begin
                    rx_done_tick = 1'b1;
                    if (rsp_cur.pre) begin
                        rx_data = 8'h1C; rsp_cur.pre = 0; rsp_cnt = 3;
                    end else begin
                        rx_data = rsp_cur.b; last_rx = cyc; rsp_pend = 0;
                    end
                end
            end
            if (tx_busy) begin
                if (tx_cnt == 0) begin
                    tx_done_tick = 1'b1;
                    tx_busy = 0;
                    last_txd = cyc;
                    if (resp_q.size() > 0) begin
                        rsp_cur  = resp_q.pop_front();
                        rsp_pend = !rsp_cur.silent;
                        rsp_cnt  = rsp_cur.dly;
                    end
                end else begin
                    tx_cnt--;
                end
            end else if (wr_ps2) begin
                tx_busy = 1; tx_cnt = 4; frames++;
                if (last_txd >= 0) gaps.push_back(cyc - last_txd);
                tests++;
                if (exp_q.size() == 0) begin
                    fails++; $display("FAIL frame_unexpected: got din=%h want no frame", din);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (din !== e) begin
                        fails++; $display("FAIL frame_din: got %h want %h", din, e);
                    end
                end
            end
        end
    end

    task automatic issue(input logic [7:0] c, input logic [7:0] a, input bit h);
        @(negedge clk);
        cmd_byte = c; arg_byte = a; has_arg = h; cmd_req = 1'b1;
        @(negedge clk);
        cmd_req = 1'b0; cmd_byte = ~c; arg_byte = ~a; has_arg = ~h;
        tests++;
        if (wr_ps2 !== 1'b1) begin
            fails++; $display("FAIL req_latency: got wr_ps2=%b want 1", wr_ps2);
        end
    endtask

    task automatic wait_end(input int d0, input int e0);
        int n;
        n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < 3000) begin
            @(negedge clk); n++;
        end
        tests++;
        if (n >= 3000) begin
            fails++; $display("FAIL wait_end: got no done/err in %0d cycles want completion", n);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        #12;
        tests++;
        if ({cmd_busy, cmd_done_tick, cmd_err_tick, wr_ps2, din} !== 12'h000) begin
            fails++; $display("FAIL reset_outputs: got %h want 000",
                              {cmd_busy, cmd_done_tick, cmd_err_tick, wr_ps2, din});
        end
`ifdef PS2_CMD_LAST_RESP_EN
        tests++;
        if (last_resp !== 8'h00) begin
            fails++; $display("FAIL reset_last_resp: got %h want 00", last_resp);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_led_ack;
        int d0, e0, f0;
        d0 = done_cnt; e0 = err_cnt; f0 = frames;
        exp_q.push_back(8'hED); exp_q.push_back(8'h02);
        push_resp(3, 0, 0, 8'hFA); push_resp(3, 0, 0, 8'hFA);
        issue(8'hED, 8'h02, 1'b1);
        wait_end(d0, e0);
        tests++;
        if (frames - f0 != 2 || done_cnt - d0 != 1 || err_cnt != e0 || exp_q.size() != 0) begin
            fails++; $display("FAIL led_ack: got frames=%0d done=%0d err=%0d left=%0d want 2 1 0 0",
                              frames - f0, done_cnt - d0, err_cnt - e0, exp_q.size());
        end
    endtask

    task automatic test_resend_retry;
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        repeat (3) exp_q.push_back(8'hF4);
        push_resp(3, 0, 0, 8'hFE); push_resp(4, 0, 0, 8'hFE); push_resp(3, 0, 0, 8'hFA);
        issue(8'hF4, 8'h00, 1'b0);
        wait_end(d0, e0);
        tests++;
        if (done_cnt - d0 != 1 || err_cnt != e0 || exp_q.size() != 0) begin
            fails++; $display("FAIL resend_retry: got done=%0d err=%0d left=%0d want 1 0 0",
                              done_cnt - d0, err_cnt - e0, exp_q.size());
        end
    endtask

    task automatic test_arg_fresh_budget;
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        repeat (4) exp_q.push_back(8'hF3);
        repeat (4) exp_q.push_back(8'h3C);
        repeat (2) begin
            repeat (3) push_resp(3, 0, 0, 8'hFE);
            push_resp(3, 0, 0, 8'hFA);
        end
        issue(8'hF3, 8'h3C, 1'b1);
        wait_end(d0, e0);
        tests++;
        if (done_cnt - d0 != 1 || err_cnt != e0 || exp_q.size() != 0) begin
            fails++; $display("FAIL arg_fresh_budget: got done=%0d err=%0d left=%0d want 1 0 0",
                              done_cnt - d0, err_cnt - e0, exp_q.size());
        end
    endtask

    task automatic test_resend_err;
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        repeat (MR + 1) exp_q.push_back(8'hED);
        repeat (MR + 1) push_resp(3, 0, 0, 8'hFE);
        issue(8'hED, 8'h07, 1'b1);
        wait_end(d0, e0);
        tests++;
        if (err_cnt - e0 != 1 || done_cnt != d0 || exp_q.size() != 0) begin
            fails++; $display("FAIL resend_err: got err=%0d done=%0d left=%0d want 1 0 0",
                              err_cnt - e0, done_cnt - d0, exp_q.size());
        end
`ifdef PS2_CMD_LAST_RESP_EN
        tests++;
        if (last_resp !== 8'hFE) begin
            fails++; $display("FAIL resend_err_last_resp: got %h want fe", last_resp);
        end
`endif
    endtask

    task automatic test_timeout;
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        gaps.delete(); last_txd = -1;
        repeat (MR + 1) exp_q.push_back(8'hF5);
        repeat (MR + 1) push_resp(0, 1, 0, 8'h00);
        issue(8'hF5, 8'h00, 1'b0);
        wait_end(d0, e0);
        tests++;
        if (err_cnt - e0 != 1 || done_cnt != d0 || exp_q.size() != 0 || gaps.size() != MR) begin
            fails++; $display("FAIL timeout_err: got err=%0d done=%0d left=%0d gaps=%0d want 1 0 0 %0d",
                              err_cnt - e0, done_cnt - d0, exp_q.size(), gaps.size(), MR);
        end
        foreach (gaps[i]) begin
            tests++;
            if (gaps[i] != TO + 1) begin
                fails++; $display("FAIL timeout_gap%0d: got %0d want %0d", i, gaps[i], TO + 1);
            end
        end
        tests++;
        if (err_gap != TO + 1) begin
            fails++; $display("FAIL timeout_err_gap: got %0d want %0d", err_gap, TO + 1);
        end
`ifdef PS2_CMD_LAST_RESP_EN
        tests++;
        if (last_resp !== 8'hFE) begin
            fails++; $display("FAIL timeout_last_resp_hold: got %h want fe", last_resp);
        end
`endif
    endtask

    task automatic test_ack_at_timeout;
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        exp_q.push_back(8'hF6);
        push_resp(TO, 0, 0, 8'hFA);
        issue(8'hF6, 8'h00, 1'b0);
        wait_end(d0, e0);
        tests++;
        if (done_cnt - d0 != 1 || err_cnt != e0 || exp_q.size() != 0) begin
            fails++; $display("FAIL ack_at_timeout: got done=%0d err=%0d left=%0d want 1 0 0",
                              done_cnt - d0, err_cnt - e0, exp_q.size());
        end
    endtask

    task automatic test_stray_and_busy;
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        exp_q.push_back(8'hF3); exp_q.push_back(8'h20);
        push_resp(3, 0, 1, 8'hFA); push_resp(3, 0, 0, 8'hFA);
        issue(8'hF3, 8'h20, 1'b1);
        repeat (8) @(negedge clk);
        cmd_byte = 8'hEE; has_arg = 1'b0; cmd_req = 1'b1;
        @(negedge clk);
        cmd_req = 1'b0;
`ifdef PS2_CMD_LAST_RESP_EN
        tests++;
        if (last_resp !== 8'h1C) begin
            fails++; $display("FAIL stray_last_resp: got %h want 1c", last_resp);
        end
`endif
        wait_end(d0, e0);
        tests++;
        if (done_cnt - d0 != 1 || err_cnt != e0 || exp_q.size() != 0) begin
            fails++; $display("FAIL stray_busy: got done=%0d err=%0d left=%0d want 1 0 0",
                              done_cnt - d0, err_cnt - e0, exp_q.size());
        end
        repeat (20) @(negedge clk);
        tests++;
        if (cmd_busy !== 1'b0) begin
            fails++; $display("FAIL req_not_queued: got busy=%b want 0", cmd_busy);
        end
`ifdef PS2_CMD_LAST_RESP_EN
        tests++;
        if (last_resp !== 8'hFA) begin
            fails++; $display("FAIL ack_last_resp: got %h want fa", last_resp);
        end
`endif
    endtask

    task automatic test_reset_mid;
        int d0, e0, n;
        d0 = done_cnt; e0 = err_cnt;
        exp_q.push_back(8'hED); exp_q.push_back(8'h04);
        push_resp(3, 0, 0, 8'hFA); push_resp(3, 0, 0, 8'hFA);
        issue(8'hED, 8'h04, 1'b1);
        n = 0;
        while (!(wr_ps2 === 1'b1 && din === 8'h04) && n < 200) begin
            @(negedge clk); n++;
        end
        tests++;
        if (n >= 200) begin
            fails++; $display("FAIL reset_mid_reach: got no arg frame in %0d cycles want arg send", n);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({cmd_busy, wr_ps2, din} !== 10'h000) begin
            fails++; $display("FAIL reset_mid_async: got busy=%b wr=%b din=%h want 0 0 00",
                              cmd_busy, wr_ps2, din);
        end
        exp_q.delete(); resp_q.delete();
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        tests++;
        if (done_cnt != d0 || err_cnt != e0) begin
            fails++; $display("FAIL reset_mid_pulse: got done=%0d err=%0d want 0 0",
                              done_cnt - d0, err_cnt - e0);
        end
        exp_q.push_back(8'hF4);
        push_resp(3, 0, 0, 8'hFA);
        issue(8'hF4, 8'h00, 1'b0);
        wait_end(d0, e0);
        tests++;
        if (done_cnt - d0 != 1 || err_cnt != e0 || exp_q.size() != 0) begin
            fails++; $display("FAIL reset_mid_recover: got done=%0d err=%0d left=%0d want 1 0 0",
                              done_cnt - d0, err_cnt - e0, exp_q.size());
        end
    endtask

    initial begin
        test_reset;
        test_led_ack;
        test_resend_retry;
        test_arg_fresh_budget;
        test_resend_err;
        test_timeout;
        test_ack_at_timeout;
        test_stray_and_busy;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
